// File: rtl/round_seq_pkg.sv
// Shared state encoding and counter-width helper for the round/step sequencer.
package round_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int cnt_w(input int mod);
    return $clog2(mod);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear/load; wraps at MOD-1 going up, at 0 going down.
// One-cycle update latency; tc is combinational from the count and direction, no backpressure.
module mod_counter
  import round_seq_pkg::*;
#(
  parameter int  MOD = 4,
  localparam int W   = cnt_w(MOD)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] load_val,
  input  logic         load,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // clr beats load beats en
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (down) begin
        cnt_d = (cnt_q == '0) ? LAST : cnt_q - W'(1);
      end else begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = down ? (cnt_q == '0) : (cnt_q == LAST);

endmodule

// File: rtl/round_step_sequencer.sv
// Inner step counter nested in an outer round counter with start/abort, busy/done and step_tc.
// Run spans INNER_MOD*OUTER_MOD busy cycles then a 1-cycle done; no backpressure. ROUND_SEQ_REVERSE_EN adds dir_down.
module round_step_sequencer
  import round_seq_pkg::*;
#(
  parameter int  INNER_MOD = 4,
  parameter int  OUTER_MOD = 10,
  localparam int IW        = cnt_w(INNER_MOD),
  localparam int OW        = cnt_w(OUTER_MOD)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic          abort,
`ifdef ROUND_SEQ_REVERSE_EN
  input  logic          dir_down,
`endif
  output logic [IW-1:0] inner_cnt,
  output logic [OW-1:0] outer_cnt,
  output logic          busy,
  output logic          step_tc,
  output logic          done
);

  localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER_MOD - 1);

  seq_state_t    state_q, state_d;
  logic          dir_q, dir_d;
  logic          start_dir;
  logic          in_clr, in_en, in_tc;
  logic          out_clr, out_en, out_load, out_tc;
  logic [OW-1:0] out_load_val;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;

`ifdef ROUND_SEQ_REVERSE_EN
  assign start_dir = dir_down;
`else
  assign start_dir = 1'b0;
`endif

  // Direction is latched on the start edge so mid-run dir_down changes are ignored.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    in_clr       = 1'b0;
    in_en        = 1'b0;
    out_clr      = 1'b0;
    out_en       = 1'b0;
    out_load     = 1'b0;
    out_load_val = '0;
    if (abort) begin
      state_d = IDLE;
      in_clr  = 1'b1;
      out_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d      = RUN;
            dir_d        = start_dir;
            in_clr       = 1'b1;
            out_load     = 1'b1;
            out_load_val = start_dir ? OUTER_LAST : '0;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (in_tc && out_tc) begin
            state_d      = DONE;
            in_clr       = 1'b1;
            out_load     = 1'b1;
            out_load_val = dir_q ? OUTER_LAST : '0;
          end else begin
            in_en  = 1'b1;
            out_en = in_tc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  mod_counter #(.MOD(INNER_MOD)) u_inner (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (in_clr),
    .en       (in_en),
    .down     (1'b0),
    .load_val ('0),
    .load     (1'b0),
    .cnt      (in_cnt),
    .tc       (in_tc)
  );

  mod_counter #(.MOD(OUTER_MOD)) u_outer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (out_clr),
    .en       (out_en),
    .down     (dir_q),
    .load_val (out_load_val),
    .load     (out_load),
    .cnt      (out_cnt),
    .tc       (out_tc)
  );

  assign inner_cnt = in_cnt;
  assign outer_cnt = out_cnt;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign step_tc   = (state_q == RUN) && in_tc;

endmodule

// File: tb/tb_round_step_sequencer.sv
// Directed bench: default 4x10 sequencer plus a 3x5 instance, each scenario checked cycle by cycle.
module tb_round_step_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start, abort, start2, abort2;
`ifdef ROUND_SEQ_REVERSE_EN
  logic       dir_down;
`endif
  logic [1:0] inner_cnt;
  logic [3:0] outer_cnt;
  logic       busy, step_tc, done;
  logic [1:0] inner2;
  logic [2:0] outer2;
  logic       busy2, step_tc2, done2;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] DONE_V = 9'b010000000;
  localparam logic [7:0] DONE2_V = 8'b01000000;

  always #5 CLK = ~CLK;

  round_step_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .abort     (abort),
`ifdef ROUND_SEQ_REVERSE_EN
    .dir_down  (dir_down),
`endif
    .inner_cnt (inner_cnt),
    .outer_cnt (outer_cnt),
    .busy      (busy),
    .step_tc   (step_tc),
    .done      (done)
  );

  round_step_sequencer #(.INNER_MOD(3), .OUTER_MOD(5)) dut2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start2),
    .abort     (abort2),
`ifdef ROUND_SEQ_REVERSE_EN
    .dir_down  (1'b0),
`endif
    .inner_cnt (inner2),
    .outer_cnt (outer2),
    .busy      (busy2),
    .step_tc   (step_tc2),
    .done      (done2)
  );

  // Expected {busy,done,step_tc,inner,outer} at position p (0-based) of a default up-run.
  function automatic logic [8:0] run_vec(input int p);
    return {1'b1, 1'b0, (p % 4 == 3), 2'(p % 4), 4'(p / 4)};
  endfunction

  function automatic logic [7:0] run2_vec(input int p);
    return {1'b1, 1'b0, (p % 3 == 2), 2'(p % 3), 3'(p / 3)};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [8:0] got;
    logic [7:0] got2;
    RESET  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
`ifdef ROUND_SEQ_REVERSE_EN
    dir_down = 1'b0;
`endif
    #2;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL reset_dut got=%b exp=%b", got, 9'd0);
    end
    got2 = {busy2, done2, step_tc2, inner2, outer2};
    total++;
    if (got2 !== 8'd0) begin
      bad++;
      $display("FAIL reset_dut2 got=%b exp=%b", got2, 8'd0);
    end
    tick;
    tick;
    RESET = 1'b0;
    tick;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL reset_release_idle got=%b exp=%b", got, 9'd0);
    end
  endtask

  task automatic test_single_run;
    logic [8:0] got, exp;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      exp = (c <= 40) ? run_vec(c - 1) : (c == 41) ? DONE_V : 9'd0;
      got = {busy, done, step_tc, inner_cnt, outer_cnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_run cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c < 42) tick;
    end
  endtask

  task automatic test_abort;
    logic [8:0] got, exp;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      exp = (c <= 17) ? run_vec(c - 1) : 9'd0;
      got = {busy, done, step_tc, inner_cnt, outer_cnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL abort cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 17) abort = 1'b1;
      tick;
      abort = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] got, exp;
    int p;
    start = 1'b1;
    tick;
    for (int c = 1; c <= 85; c++) begin
      p   = (c - 1) % 41;
      exp = (p < 40) ? run_vec(p) : DONE_V;
      got = {busy, done, step_tc, inner_cnt, outer_cnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 85) abort = 1'b1;
      tick;
    end
    abort = 1'b0;
    start = 1'b0;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL abort_over_start got=%b exp=%b", got, 9'd0);
    end
    tick;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL idle_after_abort got=%b exp=%b", got, 9'd0);
    end
  endtask

  task automatic test_small_modulus;
    logic [7:0] got, exp;
    logic [1:0] max_in;
    logic [2:0] max_out;
    max_in  = '0;
    max_out = '0;
    start2  = 1'b1;
    tick;
    start2  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      exp = (c <= 15) ? run2_vec(c - 1) : (c == 16) ? DONE2_V : 8'd0;
      got = {busy2, done2, step_tc2, inner2, outer2};
      if (inner2 > max_in) max_in = inner2;
      if (outer2 > max_out) max_out = outer2;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL small_mod cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c < 17) tick;
    end
    total++;
    if ({max_in, max_out} !== {2'd2, 3'd4}) begin
      bad++;
      $display("FAIL small_mod_max got=%0d/%0d exp=2/4", max_in, max_out);
    end
  endtask

  task automatic test_reset_midrun;
    logic [8:0] got, exp;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== run_vec(9)) begin
      bad++;
      $display("FAIL midrun_before_reset got=%b exp=%b", got, run_vec(9));
    end
    #2;
    RESET = 1'b1;
    #1;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL async_reset_immediate got=%b exp=%b", got, 9'd0);
    end
    tick;
    tick;
    RESET = 1'b0;
    tick;
    got = {busy, done, step_tc, inner_cnt, outer_cnt};
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL after_reset_no_done got=%b exp=%b", got, 9'd0);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      exp = (c <= 40) ? run_vec(c - 1) : (c == 41) ? DONE_V : 9'd0;
      got = {busy, done, step_tc, inner_cnt, outer_cnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL run_after_reset cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c < 42) tick;
    end
  endtask

`ifdef ROUND_SEQ_REVERSE_EN
  task automatic test_reverse;
    logic [8:0] got, exp;
    int p;
    dir_down = 1'b1;
    start    = 1'b1;
    tick;
    start    = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      p = c - 1;
      if (c <= 40) exp = {1'b1, 1'b0, (p % 4 == 3), 2'(p % 4), 4'(9 - p / 4)};
      else if (c == 41) exp = {1'b0, 1'b1, 1'b0, 2'd0, 4'd9};
      else exp = {1'b0, 1'b0, 1'b0, 2'd0, 4'd9};
      got = {busy, done, step_tc, inner_cnt, outer_cnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reverse cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 12) dir_down = 1'b0;
      if (c == 25) dir_down = 1'b1;
      if (c == 30) dir_down = 1'b0;
      if (c < 42) tick;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_abort();
    test_back_to_back();
    test_small_modulus();
    test_reset_midrun();
`ifdef ROUND_SEQ_REVERSE_EN
    test_reverse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
